truth_table_checker: RTL and testbench

- Sequential harness stage that sits directly downstream of the two-input gate modules (structural and expression variants of the same function).
- Drives every minterm onto the gates' shared inputs and samples both gate outputs.
- Checks each output against the other and against a parameterised expected truth table.
- Replaces hand-written #delay stimulus with a clocked, self-checking sweep whose verdict is readable as signals.

---
 rtl/tt_pkg.sv | 17 +
 rtl/minterm_sequencer.sv | 42 ++++
 rtl/truth_table_checker.sv | 117 +++++++++++
 tb/tb_truth_table_checker.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table checker and its minterm sequencer.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int MAX_N = 4;

  function automatic int minterms(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/minterm_sequencer.sv
// Walks the minterm index and times how long each minterm is held before it is sampled.
module minterm_sequencer
  import tt_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_drive,
  input  logic         i_advance,
  output logic [N-1:0] o_stim,
  output logic         o_sample_go,
  output logic         o_last
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [N-1:0] r_stim;
  logic [3:0]   r_settle;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stim   <= '0;
      r_settle <= '0;
    end else if (i_clear) begin
      r_stim   <= '0;
      r_settle <= '0;
    end else if (i_advance) begin
      r_stim   <= r_stim + 1'b1;
      r_settle <= '0;
    end else if (i_drive) begin
      r_settle <= r_settle + 4'd1;
    end
  end

  assign o_stim      = r_stim;
  assign o_sample_go = i_drive && (r_settle == SETTLE_LAST);
  assign o_last      = (r_stim == {N{1'b1}});

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every minterm through two gate variants and records where they disagree
// with each other or with the expected truth table.
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int                     N      = 2,
  parameter logic [minterms(N)-1:0] EXPECT = 4'b0010,
  parameter int                     SETTLE = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  output logic [N-1:0]           o_stim,
  input  logic                   i_res_a,
  input  logic                   i_res_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [minterms(N)-1:0] o_err_map_a,
  output logic [minterms(N)-1:0] o_err_map_ab,
  output logic [N:0]             o_err_count,
  output logic [N-1:0]           o_first_err,
  output logic                   o_first_err_valid
);

  localparam int         M         = minterms(N);
  localparam logic [N:0] COUNT_MAX = (N+1)'(M);

  state_t         r_state, w_state_nxt;
  logic           w_clear, w_sample_go, w_last, w_advance;
  logic           w_err_a, w_err_ab, w_any_err;
  logic [N-1:0]   w_stim;
  logic [M-1:0]   r_map_a, r_map_ab;
  logic [N:0]     r_count;
  logic [N-1:0]   r_first;
  logic           r_first_v, r_pass;

  minterm_sequencer #(.N(N), .SETTLE(SETTLE)) u_seq (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_clear),
    .i_drive     (r_state == ST_DRIVE),
    .i_advance   (w_advance),
    .o_stim      (w_stim),
    .o_sample_go (w_sample_go),
    .o_last      (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE:  if (w_sample_go) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = w_last ? ST_DONE : ST_DRIVE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_advance = (r_state == ST_SAMPLE) && !w_last;

  // Case-inequality so an undriven or X gate output is flagged rather than masked.
  assign w_err_a   = (i_res_a !== EXPECT[w_stim]);
  assign w_err_ab  = (i_res_a !== i_res_b);
  assign w_any_err = w_err_a | w_err_ab;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_map_a   <= '0;
      r_map_ab  <= '0;
      r_count   <= '0;
      r_first   <= '0;
      r_first_v <= 1'b0;
      r_pass    <= 1'b0;
    end else if (w_clear) begin
      r_map_a   <= '0;
      r_map_ab  <= '0;
      r_count   <= '0;
      r_first   <= '0;
      r_first_v <= 1'b0;
      r_pass    <= 1'b0;
    end else if (r_state == ST_SAMPLE) begin
      r_map_a[w_stim]  <= w_err_a;
      r_map_ab[w_stim] <= w_err_ab;
      if (w_any_err) begin
        if (r_count != COUNT_MAX) r_count <= r_count + 1'b1;
        if (!r_first_v) begin
          r_first   <= w_stim;
          r_first_v <= 1'b1;
        end
      end
      // Fold in the final sample so pass is valid in the first DONE cycle.
      if (w_last) r_pass <= (r_map_a == '0) && (r_map_ab == '0) && !w_any_err;
    end
  end

  assign o_stim            = w_stim;
  assign o_busy            = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
  assign o_done            = (r_state == ST_DONE);
  assign o_pass            = r_pass;
  assign o_err_map_a       = r_map_a;
  assign o_err_map_ab      = r_map_ab;
  assign o_err_count       = r_count;
  assign o_first_err       = r_first;
  assign o_first_err_valid = r_first_v;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: a table of gate-behaviour modes for the default checker plus
// hand-written sequences for restart, ignored start, mid-sweep reset and N=3.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance: N=2, EXPECT=4'b0010, SETTLE=1
  logic       start0 = 1'b0;
  logic [1:0] stim0;
  logic       res_a0, res_b0;
  logic       busy0, done0, pass0, fv0;
  logic [3:0] map_a0, map_ab0;
  logic [2:0] cnt0;
  logic [1:0] first0;
  int         mode = 0;

  truth_table_checker u_dut0 (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (start0), .o_stim (stim0),
    .i_res_a (res_a0), .i_res_b (res_b0), .o_busy (busy0), .o_done (done0),
    .o_pass (pass0), .o_err_map_a (map_a0), .o_err_map_ab (map_ab0),
    .o_err_count (cnt0), .o_first_err (first0), .o_first_err_valid (fv0)
  );

  // mode 0: both a'.b   1: a=a'.b, b=~a|~b   2: both 1   3: a=a'.b, b=0
  always_comb begin
    res_a0 = !stim0[1] && stim0[0];
    res_b0 = res_a0;
    case (mode)
      1:       res_b0 = !stim0[1] || !stim0[0];
      2:       begin res_a0 = 1'b1; res_b0 = 1'b1; end
      3:       res_b0 = 1'b0;
      default: res_b0 = res_a0;
    endcase
  end

  // N=3 instance: EXPECT=8'h80, SETTLE=3, both variants a&b&c
  logic       start1 = 1'b0;
  logic [2:0] stim1;
  logic       res1;
  logic       busy1, done1, pass1, fv1;
  logic [7:0] map_a1, map_ab1;
  logic [3:0] cnt1;
  logic [2:0] first1;

  assign res1 = &stim1;

  truth_table_checker #(.N(3), .EXPECT(8'h80), .SETTLE(3)) u_dut1 (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (start1), .o_stim (stim1),
    .i_res_a (res1), .i_res_b (res1), .o_busy (busy1), .o_done (done1),
    .o_pass (pass1), .o_err_map_a (map_a1), .o_err_map_ab (map_ab1),
    .o_err_count (cnt1), .o_first_err (first1), .o_first_err_valid (fv1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulses start0 and follows the sweep; cycle 1 is the cycle after the start edge.
  task automatic run_sweep0(output int lat, output int stim_bad, output int clr_bad);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    lat = 0; stim_bad = 0; clr_bad = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1 && (cnt0 != 0 || fv0 || map_a0 != 0 || map_ab0 != 0 || done0 || pass0))
        clr_bad++;
      if (done0) begin lat = c; break; end
      if (stim0 != 2'((c - 1) / 2) || !busy0) stim_bad++;
    end
  endtask

  typedef struct {
    int       mode;
    logic [3:0] map_a;
    logic [3:0] map_ab;
    int       count;
    int       first;
    logic     fv;
    logic     pass;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, sb, cb;

    vecs[0] = '{0, 4'b0000, 4'b0000, 0, 0, 1'b0, 1'b1};
    vecs[1] = '{1, 4'b0000, 4'b0101, 2, 0, 1'b1, 1'b0};
    vecs[2] = '{2, 4'b1101, 4'b0000, 3, 0, 1'b1, 1'b0};
    vecs[3] = '{0, 4'b0000, 4'b0000, 0, 0, 1'b0, 1'b1};
    vecs[4] = '{3, 4'b0000, 4'b0010, 1, 1, 1'b1, 1'b0};

    #1;
    chk("reset_busy", busy0, 0);
    chk("reset_outs", {done0, pass0, fv0, map_a0, map_ab0, cnt0, first0, stim0}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {busy0, done0, pass0, fv0, cnt0, stim0}, 0);

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      run_sweep0(lat, sb, cb);
      chk($sformatf("v%0d_latency", i), lat, 9);
      chk($sformatf("v%0d_stim_seq", i), sb, 0);
      chk($sformatf("v%0d_cleared", i), cb, 0);
      chk($sformatf("v%0d_map_a", i), map_a0, vecs[i].map_a);
      chk($sformatf("v%0d_map_ab", i), map_ab0, vecs[i].map_ab);
      chk($sformatf("v%0d_count", i), cnt0, vecs[i].count);
      chk($sformatf("v%0d_first_valid", i), fv0, vecs[i].fv);
      if (vecs[i].fv) chk($sformatf("v%0d_first", i), first0, vecs[i].first);
      chk($sformatf("v%0d_pass", i), pass0, vecs[i].pass);
      @(negedge clk);
      chk($sformatf("v%0d_hold", i), {done0, map_ab0, cnt0}, {1'b1, vecs[i].map_ab, 3'(vecs[i].count)});
    end

    // Ignored start during DRIVE of minterm 1, then reset during SAMPLE of minterm 2.
    mode = 1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_stim_c3", stim0, 1);
    start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    chk("mid_stim_c4", stim0, 1);
    repeat (2) @(negedge clk);
    chk("mid_stim_c6", {busy0, stim0}, {1'b1, 2'd2});
    chk("mid_partial_count", cnt0, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy0, done0, pass0, fv0, map_a0, map_ab0, cnt0, first0, stim0}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {busy0, done0}, 0);
    mode = 0;
    run_sweep0(lat, sb, cb);
    chk("fresh_latency", lat, 9);
    chk("fresh_stim_seq", sb, 0);
    chk("fresh_pass", {pass0, cnt0, fv0}, {1'b1, 3'd0, 1'b0});

    // N=3, SETTLE=3 sweep
    begin
      int lat1 = 0, sb1 = 0;
      @(negedge clk); start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      for (int c = 1; c <= 100; c++) begin
        @(negedge clk);
        if (done1) begin lat1 = c; break; end
        if (stim1 != 3'((c - 1) / 4)) sb1++;
      end
      chk("n3_latency", lat1, 33);
      chk("n3_stim_seq", sb1, 0);
      chk("n3_pass", pass1, 1);
      chk("n3_count", {cnt1, fv1, map_a1, map_ab1}, 0);
      chk("n3_count_width", $bits(cnt1), 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
